// File: rtl/ula_seq_pkg.sv
// Shared opcode constants, FSM state encoding and default width for ula_seq.
package ula_seq_pkg;

   localparam int unsigned DefaultWidth = 8;

   localparam int unsigned OpAdd = 0;
   localparam int unsigned OpSub = 1;
   localparam int unsigned OpAnd = 2;
   localparam int unsigned OpOr  = 3;
   localparam int unsigned OpMul = 4;
   localparam int unsigned OpDiv = 5;
   localparam int unsigned OpXor = 6;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StDone
   } state_t;

endpackage

// File: rtl/ula_seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider, WIDTH steps per operation.
// The divider is only built when ULA_SEQ_DIV_EN is defined.
module ula_seq_muldiv
   import ula_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   // acc holds {partial product, multiplier} or {remainder, quotient}
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH:0]     add_hi;
   logic               div_mode;
   logic               busy;
   logic [CW-1:0]      cnt;

   always_comb begin
      add_hi   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next = {add_hi, acc[WIDTH-1:1]};
   end

`ifdef ULA_SEQ_DIV_EN
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial    = shifted - {1'b0, opb};
      div_next = {(trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0]),
                  acc[WIDTH-2:0], ~trial[WIDTH]};
   end
`else
   assign div_next = mul_next;
`endif

   // Result is taken from the final step so the top can latch it on the last EXEC edge
   assign acc_next = div_mode ? div_next : mul_next;
   assign result   = acc_next[WIDTH-1:0];
   assign ovf      = div_mode ? 1'b0 : |acc_next[2*WIDTH-1:WIDTH];
   assign done     = busy && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= '0;
         opb      <= '0;
         div_mode <= 1'b0;
         busy     <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
         opb      <= is_div ? b : a;
         div_mode <= is_div;
         busy     <= 1'b1;
         cnt      <= '0;
      end else if (busy) begin
         acc <= acc_next;
         cnt <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU with valid/ready handshakes; MUL/DIV run in ula_seq_muldiv.
// Divider enabled by defining ULA_SEQ_DIV_EN; otherwise opcode 5 acts as reserved.
module ula_seq
   import ula_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operator1,
   input  logic [WIDTH-1:0] operator2,
   input  logic [OPW-1:0]   operation_alu,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_alu,
   output logic             overflow
);

   state_t           state;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] simple_res;
   logic             simple_ovf;
   logic             use_md;
   logic             is_div;
   logic             md_start;
   logic             md_done;
   logic [WIDTH-1:0] md_result;
   logic             md_ovf;

   always_comb begin
      sum        = {1'b0, operator1} + {1'b0, operator2};
      simple_res = '0;
      simple_ovf = 1'b1;
      use_md     = 1'b0;
      is_div     = 1'b0;
      case (operation_alu)
         OPW'(OpAdd): begin simple_res = sum[WIDTH-1:0];        simple_ovf = sum[WIDTH];             end
         OPW'(OpSub): begin simple_res = operator1 - operator2; simple_ovf = operator1 < operator2;  end
         OPW'(OpAnd): begin simple_res = operator1 & operator2; simple_ovf = 1'b0;                  end
         OPW'(OpOr):  begin simple_res = operator1 | operator2; simple_ovf = 1'b0;                  end
         OPW'(OpXor): begin simple_res = operator1 ^ operator2; simple_ovf = 1'b0;                  end
         OPW'(OpMul): use_md = 1'b1;
         OPW'(OpDiv): begin
`ifdef ULA_SEQ_DIV_EN
            if (operator2 == '0) begin
               simple_res = '1;
            end else begin
               use_md = 1'b1;
               is_div = 1'b1;
            end
`else
            simple_res = '0;
`endif
         end
         default: ;
      endcase
   end

   assign in_ready  = (state == StIdle);
   assign out_valid = (state == StDone);
   assign md_start  = in_ready && in_valid && use_md;

   ula_seq_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .is_div (is_div),
      .a      (operator1),
      .b      (operator2),
      .done   (md_done),
      .result (md_result),
      .ovf    (md_ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= StIdle;
         result_alu <= '0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (in_valid) begin
                  if (use_md) begin
                     state <= StExec;
                  end else begin
                     state      <= StDone;
                     result_alu <= simple_res;
                     overflow   <= simple_ovf;
                  end
               end
            end
            StExec: begin
               if (md_done) begin
                  state      <= StDone;
                  result_alu <= md_result;
                  overflow   <= md_ovf;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_seq.sv
// Randomized and directed bench for ula_seq (WIDTH = 8) against an arithmetic reference model.
module tb_ula_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] operator1 = '0;
   logic [W-1:0] operator2 = '0;
   logic [2:0]   operation_alu = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result_alu;
   logic         overflow;

   int vectors = 0;
   int miscompares = 0;

   ula_seq #(
      .WIDTH (W),
      .OPW   (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .operator1     (operator1),
      .operator2     (operator2),
      .operation_alu (operation_alu),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result_alu    (result_alu),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   function automatic void model(input int op, input int a, input int b,
                                 output int res, output bit ovf, output int lat);
      int full;
      lat = 1;
      case (op)
         0: begin full = a + b; res = full % 256; ovf = full > 255; end
         1: begin res = (a - b + 256) % 256; ovf = a < b; end
         2: begin res = a & b; ovf = 0; end
         3: begin res = a | b; ovf = 0; end
         4: begin full = a * b; res = full % 256; ovf = full > 255; lat = 9; end
         5: begin
`ifdef ULA_SEQ_DIV_EN
            if (b == 0) begin res = 255; ovf = 1; end
            else begin res = a / b; ovf = 0; lat = 9; end
`else
            res = 0; ovf = 1;
`endif
         end
         6: begin res = a ^ b; ovf = 0; end
         default: begin res = 0; ovf = 1; end
      endcase
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_op(input int op, input int a, input int b, input string name);
      int exp_res, exp_lat, lat;
      bit exp_ovf;
      model(op, a, b, exp_res, exp_ovf, exp_lat);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
      end
      in_valid = 1'b1; operation_alu = 3'(op); operator1 = W'(a); operator2 = W'(b);
      @(negedge clk);
      in_valid = 1'b0; operator1 = W'($urandom); operator2 = W'($urandom);
      operation_alu = 3'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      vectors++;
      if (lat !== exp_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      vectors++;
      if (result_alu !== W'(exp_res) || overflow !== exp_ovf) begin
         miscompares++;
         $display("FAIL %s op=%0d a=%0d b=%0d: got res=%0d ovf=%b want res=%0d ovf=%b",
                  name, op, a, b, result_alu, overflow, exp_res, exp_ovf);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1",
                  name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || result_alu !== '0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset state: got out_valid=%b res=%0d ovf=%b want 0/0/0",
                  out_valid, result_alu, overflow);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      run_op(0, 200, 100, "add_carry");
      run_op(0, 3, 4, "add_small");
      run_op(1, 5, 7, "sub_wrap");
      run_op(1, 7, 5, "sub_plain");
      run_op(4, 16, 17, "mul_ovf");
      run_op(4, 15, 17, "mul_fit");
      run_op(5, 200, 7, "div");
      run_op(5, 200, 0, "div_zero");
      run_op(7, 9, 3, "reserved");
      run_op(2, 8'hF0, 8'h3C, "and");
      run_op(3, 8'hF0, 8'h0C, "or");
      run_op(6, 8'hFF, 8'h0F, "xor");
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int op, a, b;
         op = int'($urandom_range(0, 7));
         a  = int'($urandom_range(0, 255));
         b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
         run_op(op, a, b, "random");
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         run_op(i % 8, int'($urandom_range(0, 255)), int'($urandom_range(1, 255)), "b2b");
      end
   endtask

   task automatic test_backpressure();
      int n;
      in_valid = 1'b1; operation_alu = 3'd4; operator1 = 8'd16; operator2 = 8'd17;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; operation_alu = 3'd0;
         operator1 = W'($urandom); operator2 = W'($urandom);
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_alu !== 8'd16 ||
             overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL backpressure hold %0d: got v=%b rdy=%b res=%0d ovf=%b want 1/0/16/1",
                     i, out_valid, in_ready, result_alu, overflow);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure release: got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      in_valid = 1'b1; operation_alu = 3'd4; operator1 = 8'd200; operator2 = 8'd200;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if (out_valid !== 1'b0 || result_alu !== '0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid state: got v=%b res=%0d ovf=%b rdy=%b want 0/0/0/1",
                  out_valid, result_alu, overflow, in_ready);
      end
      seen = 1'b0;
      out_ready = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      out_ready = 1'b0;
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid stale result: got out_valid seen=%b want 0", seen);
      end
      run_op(0, 3, 4, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
